// File: rtl/booth_mul_4bits.sv
// Sequential signed 4x4 radix-2 Booth multiplier driving one add_sub_4bits per step.
// Optional macro BOOTH_MUL_ZSKIP_EN: a zero operand skips CALC and finishes in one cycle.

module add_sub_4bits (
    input  logic [3:0] A,
    input  logic [3:0] B,
    input  logic       M,
    output logic [3:0] S,
    output logic       V
);
    logic [3:0] w_bEff;

    // M=1 turns the adder into A - B through two's-complement of B
    assign w_bEff = B ^ {4{M}};
    assign S      = A + w_bEff + {3'b000, M};
    assign V      = (A[3] == w_bEff[3]) && (S[3] != A[3]);
endmodule

module booth_mul_4bits (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic [3:0] mcand,
    input  logic [3:0] mplier,
    output logic       busy,
    output logic       done,
    output logic [7:0] product
);
    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_CALC = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    logic [1:0] r_state;
    logic [3:0] r_acc;
    logic [3:0] r_q;
    logic       r_q1;
    logic [3:0] r_m;
    logic [1:0] r_cnt;
    logic [7:0] r_product;

    logic [1:0] w_op;
    logic       w_sub;
    logic       w_doArith;
    logic [3:0] w_sum;
    logic       w_ovf;
    logic [3:0] w_r;
    logic       w_sign;
    logic [3:0] w_nextAcc;
    logic [3:0] w_nextQ;

    assign w_op      = {r_q[0], r_q1};
    assign w_sub     = (w_op == 2'b10);
    assign w_doArith = w_op[1] ^ w_op[0];

    add_sub_4bits u_addSub (
        .A (r_acc),
        .B (r_m),
        .M (w_sub),
        .S (w_sum),
        .V (w_ovf)
    );

    // Sign shifted in is the true sign of the add/sub, so 0-(-8) still shifts correctly
    assign w_r       = w_doArith ? w_sum : r_acc;
    assign w_sign    = w_doArith ? (w_sum[3] ^ w_ovf) : r_acc[3];
    assign w_nextAcc = {w_sign, w_r[3:1]};
    assign w_nextQ   = {w_r[0], r_q[3:1]};

`ifdef BOOTH_MUL_ZSKIP_EN
    logic w_zeroOp;
    assign w_zeroOp = (mcand == 4'd0) || (mplier == 4'd0);
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= S_IDLE;
            r_acc     <= 4'd0;
            r_q       <= 4'd0;
            r_q1      <= 1'b0;
            r_m       <= 4'd0;
            r_cnt     <= 2'd0;
            r_product <= 8'd0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (start) begin
`ifdef BOOTH_MUL_ZSKIP_EN
                        if (w_zeroOp) begin
                            r_state   <= S_DONE;
                            r_product <= 8'd0;
                        end else begin
                            r_state <= S_CALC;
                        end
`else
                        r_state <= S_CALC;
`endif
                        r_acc <= 4'd0;
                        r_q   <= mplier;
                        r_q1  <= 1'b0;
                        r_m   <= mcand;
                        r_cnt <= 2'd0;
                    end
                end
                S_CALC: begin
                    r_acc <= w_nextAcc;
                    r_q   <= w_nextQ;
                    r_q1  <= r_q[0];
                    r_cnt <= r_cnt + 2'd1;
                    if (r_cnt == 2'd3) begin
                        r_product <= {w_nextAcc, w_nextQ};
                        r_state   <= S_DONE;
                    end
                end
                S_DONE: begin
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign busy    = (r_state == S_CALC);
    assign done    = (r_state == S_DONE);
    assign product = r_product;
endmodule

// File: tb/tb_booth_mul_4bits.sv
// Self-checking bench for booth_mul_4bits: fixed vectors, random and exhaustive sweeps vs signed multiply,
// plus hand-written sequences for ignored start, mid-operation reset and zero operands (BOOTH_MUL_ZSKIP_EN aware).

module tb_booth_mul_4bits;
    logic       clk;
    logic       rst;
    logic       start;
    logic [3:0] mcand;
    logic [3:0] mplier;
    logic       busy;
    logic       done;
    logic [7:0] product;

    int checks;
    int failures;

    booth_mul_4bits dut (
        .clk     (clk),
        .rst     (rst),
        .start   (start),
        .mcand   (mcand),
        .mplier  (mplier),
        .busy    (busy),
        .done    (done),
        .product (product)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [3:0] a;
        logic [3:0] b;
        logic [7:0] expP;
    } vec_t;

    // Reference: plain signed product of the two 4-bit operands
    function automatic logic [7:0] refMul(input logic [3:0] a, input logic [3:0] b);
        int prod;
        prod = $signed(a) * $signed(b);
        return prod[7:0];
    endfunction

    function automatic int expLat(input logic [3:0] a, input logic [3:0] b);
`ifdef BOOTH_MUL_ZSKIP_EN
        if (a == 4'd0 || b == 4'd0) return 0;
`endif
        return 4;
    endfunction

    task automatic checkOutput(input string name, input int actual, input int expected);
        checks++;
        if (actual != expected) begin
            failures++;
            $display("[TB] FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", name, actual, actual, expected, expected);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One full operation; lat counts edges after the accepting edge until done is seen
    task automatic applyStimulus(input logic [3:0] a, input logic [3:0] b,
                                 output logic [7:0] p, output int lat,
                                 output int busyCnt, output int donePulses);
        start  = 1'b1;
        mcand  = a;
        mplier = b;
        tick();
        start  = 1'b0;
        mcand  = 4'($urandom);
        mplier = 4'($urandom);
        lat = 0;
        busyCnt = 0;
        while (!done && lat < 20) begin
            if (busy) busyCnt++;
            tick();
            lat++;
        end
        p = product;
        donePulses = done ? 1 : 0;
        tick();
        if (done) donePulses++;
    endtask

    task automatic runAndCheck(input string name, input logic [3:0] a, input logic [3:0] b,
                               input logic [7:0] expP, input bit full);
        logic [7:0] p;
        int lat, bc, dp;
        applyStimulus(a, b, p, lat, bc, dp);
        checkOutput({name, ".product"}, int'(p), int'(expP));
        if (full) begin
            checkOutput({name, ".latency"}, lat, expLat(a, b));
            checkOutput({name, ".busyCycles"}, bc, expLat(a, b));
            checkOutput({name, ".donePulses"}, dp, 1);
        end
    endtask

    initial begin
        vec_t vecs[6];
        logic [7:0] p;
        int lat, bc, dp, cyc;

        checks = 0;
        failures = 0;
        rst = 1'b1;
        start = 1'b0;
        mcand = 4'd0;
        mplier = 4'd0;
        tick();
        tick();
        checkOutput("reset.busy", int'(busy), 0);
        checkOutput("reset.done", int'(done), 0);
        checkOutput("reset.product", int'(product), 0);
        rst = 1'b0;
        tick();

        vecs[0] = '{4'd7, 4'd6, 8'h2A};
        vecs[1] = '{4'h8, 4'h8, 8'h40};
        vecs[2] = '{4'h8, 4'd7, 8'hC8};
        vecs[3] = '{4'd3, 4'hF, 8'hFD};
        vecs[4] = '{4'hB, 4'd3, 8'hF1};
        vecs[5] = '{4'd0, 4'd5, 8'h00};
        for (int i = 0; i < 6; i++) begin
            runAndCheck($sformatf("vec%0d", i), vecs[i].a, vecs[i].b, vecs[i].expP, 1'b1);
        end

        // Product must hold while idle
        runAndCheck("hold", 4'd5, 4'd5, 8'h19, 1'b1);
        repeat (3) tick();
        checkOutput("hold.product", int'(product), 8'h19);

        for (int i = 0; i < 40; i++) begin
            logic [3:0] a, b;
            a = 4'($urandom);
            b = 4'($urandom);
            runAndCheck($sformatf("rand%0d", i), a, b, refMul(a, b), 1'b1);
        end

        for (int i = 0; i < 256; i++) begin
            logic [7:0] ab;
            ab = 8'(i);
            runAndCheck($sformatf("sweep%0d", i), ab[7:4], ab[3:0], refMul(ab[7:4], ab[3:0]), 1'b0);
        end

        // Second start while busy must be ignored
        start = 1'b1;
        mcand = 4'd7;
        mplier = 4'd6;
        tick();
        start = 1'b0;
        tick();
        start = 1'b1;
        mcand = 4'd3;
        mplier = 4'd3;
        tick();
        start = 1'b0;
        cyc = 0;
        while (!done && cyc < 20) begin
            tick();
            cyc++;
        end
        checkOutput("ignore.product", int'(product), 8'h2A);
        dp = 0;
        for (int i = 0; i < 8; i++) begin
            if (done) dp++;
            tick();
        end
        checkOutput("ignore.donePulses", dp, 1);
        checkOutput("ignore.busyAfter", int'(busy), 0);

        // Reset in the middle of CALC discards the operation
        start = 1'b1;
        mcand = 4'd7;
        mplier = 4'd3;
        tick();
        start = 1'b0;
        tick();
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        checkOutput("midRst.busy", int'(busy), 0);
        checkOutput("midRst.done", int'(done), 0);
        checkOutput("midRst.product", int'(product), 0);
        runAndCheck("afterRst", 4'd2, 4'd2, 8'h04, 1'b1);

        // start and rst together: rst wins
        rst = 1'b1;
        start = 1'b1;
        mcand = 4'd3;
        mplier = 4'd3;
        tick();
        rst = 1'b0;
        start = 1'b0;
        checkOutput("rstStart.busy", int'(busy), 0);
        dp = 0;
        for (int i = 0; i < 6; i++) begin
            if (done || busy) dp++;
            tick();
        end
        checkOutput("rstStart.activity", dp, 0);
        checkOutput("rstStart.product", int'(product), 0);

        runAndCheck("zeroB", 4'd6, 4'd0, 8'h00, 1'b1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
